shifter_iterative: RTL and testbench
====================================

// Module: shifter_iterative
// PURPOSE
//  Multi-cycle 16-bit shifter/rotator: one bit position per clock, start/done handshake.
//  Adds rotate-right, the opposite direction of the existing rotate-left datapath.
//  Sits beside the combinational barrel shifter in the execute stage as a low-area path.
//  Op encoding matches the barrel shifter (ROL/SLL/SRA/SRL); ROR is added.
// PARAMETERS
//  WIDTH   16  data width in bits
//  CNT_W   4   shift-count width; must equal log2(WIDTH)
// PORTS
//  clk    in   1        clock; all state updates on rising edge
//  rst_n  in   1        asynchronous, active-low reset
//  Start  in   1        request; sampled only when the block is ready (IDLE or DONE)
//  In     in   WIDTH    operand; captured on the accepted Start
//  Cnt    in   CNT_W    shift amount 0..15; captured on the accepted Start
//  Op     in   3        000 ROL, 001 SLL, 010 SRA, 011 SRL, 100 ROR, 101-111 reserved
//  Busy   out  1        high while in SHIFT
//  Done   out  1        one-cycle pulse; Out is valid in that cycle
//  Err    out  1        one-cycle pulse with Done when the captured Op is reserved
//  Out    out  WIDTH    result; held from Done until the next accepted Start
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, Out=0, Busy=0, Done=0, Err=0, internal regs=0.
//  Reset mid-operation aborts the operation; no Done is issued for it.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : Start=1 -> capture In/Op into data reg, Cnt into counter;
//          Cnt==0 or reserved Op -> DONE, else -> SHIFT.
//   SHIFT: each cycle, apply a 1-bit step to the data reg and decrement the counter.
//          The step that takes the counter from 1 to 0 -> DONE.
//   DONE : Done=1, Out=data reg. Start=1 here is accepted (same rules as IDLE), else -> IDLE.
//  1-bit step per Op, with d = data reg:
//   ROL {d[14:0],d[15]}; SLL {d[14:0],1'b0}; SRA {d[15],d[15:1]};
//   SRL {1'b0,d[15:1]};  ROR {d[0],d[15:1]}.
//  Latency: Start accepted at edge t -> Done high in cycle t+Cnt+1.
//   Cnt=0 gives Done at t+1 with Out=In.
//  Busy is low in IDLE and DONE, so back-to-back ops are possible with no idle gap.
//  Start while Busy=1 is ignored; In/Cnt/Op changes during SHIFT have no effect.
//  Reserved Op: no shifting; DONE at t+1 with Out=In and Err=1.
//  Out is updated only on entry to DONE; it is stable in IDLE and SHIFT.
//  Counter never wraps: decrement happens only in SHIFT, where the counter is >=1.
// TESTING
//  1. ROL In=16'h8001 Cnt=1 -> Done at t+2, Out=16'h0003, Busy high exactly 1 cycle.
//  2. SRA In=16'h8000 Cnt=15 -> Done at t+16, Out=16'hFFFF.
//     SRL same operands -> Out=16'h0001.
//  3. ROR In=16'h0001 Cnt=4 -> Out=16'h1000.
//     SLL In=16'h1234 Cnt=0 -> Done at t+1, Out=16'h1234.
//  4. Start SLL 16'h0001 Cnt=8; pulse Start with new operands during Busy
//     -> ignored, Out=16'h0100. Start asserted in the DONE cycle -> accepted back-to-back.
//  5. Drop rst_n in the 3rd SHIFT cycle of ROR Cnt=10 -> Out=0, Busy=0, no Done;
//     a fresh op after release completes correctly.
//  6. Op=3'b110 In=16'hBEEF Cnt=5 -> Done and Err at t+1, Out=16'hBEEF.

Source files
------------

// File: rtl/shifter_iterative_if.sv
// Start/done bus between the execute stage and the iterative shifter.
// Master drives the request fields; slave returns status and result.
interface shifter_iterative_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
);
   // Start is taken only while Busy is low; Done pulses once per accepted Start
   // and Out then holds until the next accepted Start.
   logic             Start;
   logic [WIDTH-1:0] In;
   logic [CNT_W-1:0] Cnt;
   logic [2:0]       Op;
   logic             Busy;
   logic             Done;
   logic             Err;
   logic [WIDTH-1:0] Out;

   modport master (output Start, In, Cnt, Op, input Busy, Done, Err, Out);
   modport slave  (input Start, In, Cnt, Op, output Busy, Done, Err, Out);
endinterface

// File: rtl/shifter_iterative.sv
// Multi-cycle shifter/rotator moving one bit position per clock.
// Supports ROL, SLL, SRA, SRL and ROR; reserved ops finish at once with Err.
module shifter_iterative #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   shifter_iterative_if.slave   bus,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_out;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic [WIDTH-1:0] w_step;
   logic             w_reserved;

   assign w_reserved = (bus.Op > OP_ROR);

   always_comb begin
      w_step = r_data;
      case (r_op)
         OP_ROL:  w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
         OP_SLL:  w_step = {r_data[WIDTH-2:0], 1'b0};
         OP_SRA:  w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
         OP_SRL:  w_step = {1'b0, r_data[WIDTH-1:1]};
         OP_ROR:  w_step = {r_data[0], r_data[WIDTH-1:1]};
         default: w_step = r_data;
      endcase
   end

   // DONE accepts a new Start exactly like IDLE so ops can run back to back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_op    <= '0;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               if (bus.Start) begin
                  r_data <= bus.In;
                  r_cnt  <= bus.Cnt;
                  r_op   <= bus.Op;
                  if (bus.Cnt == '0 || w_reserved) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= w_reserved;
                     r_out   <= bus.In;
                  end else begin
                     r_state <= S_SHIFT;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               r_data <= w_step;
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_out   <= w_step;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy = r_busy;
   assign bus.Done = r_done;
   assign bus.Err  = r_err;
   assign bus.Out  = r_out;
   assign o_state  = r_state;

endmodule

// File: tb/tb_shifter_iterative.sv
// Bench for shifter_iterative: arithmetic reference model, per-cycle compare,
// directed cases with literal results, then randomized operations.
module tb_shifter_iterative;
   localparam int W  = 16;
   localparam int CW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   shifter_iterative_if #(.WIDTH(W), .CNT_W(CW)) bus();

   shifter_iterative #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .o_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result of shifting x by c positions, computed in one go.
   function automatic logic [15:0] ref_fn(input logic [2:0] op, input logic [15:0] x, input int c);
      int unsigned       u;
      logic signed [15:0] s;
      u = x;
      s = x;
      case (op)
         3'd0:    return 16'((u << c) | (u >> (16 - c)));
         3'd1:    return 16'(u << c);
         3'd2:    return 16'(s >>> c);
         3'd3:    return 16'(u >> c);
         3'd4:    return 16'((u >> c) | (u << (16 - c)));
         default: return x;
      endcase
   endfunction

   // Timing model: a non-reserved op with c>0 keeps the block busy for c cycles.
   logic        m_busy, m_done, m_err;
   logic [15:0] m_out, m_pend;
   int          m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_out = '0; m_pend = '0; m_left = 0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_out  = m_pend;
            end
         end else if (bus.Start) begin
            if (bus.Op > 3'd4) begin
               m_done = 1'b1; m_err = 1'b1; m_out = bus.In;
            end else if (bus.Cnt == 4'd0) begin
               m_done = 1'b1; m_out = bus.In;
            end else begin
               m_busy = 1'b1;
               m_left = int'(bus.Cnt);
               m_pend = ref_fn(bus.Op, bus.In, int'(bus.Cnt));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("cyc_busy", 32'(bus.Busy), 32'(m_busy));
         check("cyc_done", 32'(bus.Done), 32'(m_done));
         check("cyc_err",  32'(bus.Err),  32'(m_err));
         check("cyc_out",  32'(bus.Out),  32'(m_out));
      end
   end

   task automatic start_op(input logic [2:0] op, input logic [15:0] x, input logic [3:0] c);
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.In    = x;
      bus.Cnt   = c;
   endtask

   // Called on the negedge where Start was raised; returns on the Done negedge.
   task automatic wait_done(input string name, input int exp_k, input logic [15:0] exp_out,
                            input logic exp_err);
      int k = 0;
      int busy_n = 0;
      bit got = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) bus.Start = 1'b0;
         if (bus.Busy) busy_n++;
         if (bus.Done) begin
            k = i;
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: no Done within 40 cycles, expected after %0d", name, exp_k);
      end else begin
         check({name, "_lat"},   32'(k),        32'(exp_k));
         check({name, "_out"},   32'(bus.Out),  32'(exp_out));
         check({name, "_model"}, 32'(m_out),    32'(exp_out));
         check({name, "_err"},   32'(bus.Err),  32'(exp_err));
         check({name, "_busy"},  32'(busy_n),   32'(exp_k - 1));
      end
   endtask

   initial begin
      logic [2:0]  r_op_v;
      logic [15:0] r_in_v;
      int          r_cnt_v;
      int          r_k;

      bus.Start = 1'b0; bus.In = '0; bus.Cnt = '0; bus.Op = '0;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      check("rst_out",   32'(bus.Out),  32'h0);
      check("rst_busy",  32'(bus.Busy), 32'h0);
      check("rst_done",  32'(bus.Done), 32'h0);
      check("rst_err",   32'(bus.Err),  32'h0);
      check("rst_state", 32'(dbg_state), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      start_op(3'd0, 16'h8001, 4'd1);  wait_done("rol_8001_1", 2, 16'h0003, 1'b0);
      start_op(3'd2, 16'h8000, 4'd15); wait_done("sra_8000_15", 16, 16'hFFFF, 1'b0);
      start_op(3'd3, 16'h8000, 4'd15); wait_done("srl_8000_15", 16, 16'h0001, 1'b0);
      start_op(3'd4, 16'h0001, 4'd4);  wait_done("ror_0001_4", 5, 16'h1000, 1'b0);
      start_op(3'd1, 16'h1234, 4'd0);  wait_done("sll_1234_0", 1, 16'h1234, 1'b0);
      @(negedge clk);

      // A Start pulse while busy must be dropped; the DONE-cycle Start is taken.
      start_op(3'd1, 16'h0001, 4'd8);
      @(negedge clk); bus.Start = 1'b0;
      @(negedge clk); start_op(3'd3, 16'hFFFF, 4'd3);
      wait_done("sll_ignore", 7, 16'h0100, 1'b0);
      start_op(3'd4, 16'h0001, 4'd4);  wait_done("ror_b2b", 5, 16'h1000, 1'b0);

      start_op(3'd6, 16'hBEEF, 4'd5);  wait_done("rsv_beef", 1, 16'hBEEF, 1'b1);
      @(negedge clk);

      // Abort a ROR in its third shift cycle with an asynchronous reset.
      start_op(3'd4, 16'hABCD, 4'd10);
      @(negedge clk); bus.Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out",  32'(bus.Out),  32'h0);
      check("abort_busy", 32'(bus.Busy), 32'h0);
      check("abort_done", 32'(bus.Done), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      start_op(3'd0, 16'h8001, 4'd1);  wait_done("post_rst_rol", 2, 16'h0003, 1'b0);

      for (int i = 0; i < 80; i++) begin
         r_op_v  = 3'($urandom_range(0, 7));
         r_in_v  = 16'($urandom);
         r_cnt_v = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         start_op(r_op_v, r_in_v, 4'(r_cnt_v));
         r_k = (r_op_v > 3'd4 || r_cnt_v == 0) ? 1 : r_cnt_v + 1;
         wait_done("rand", r_k, ref_fn(r_op_v, r_in_v, r_cnt_v), r_op_v > 3'd4);
      end

      repeat (3) @(negedge clk);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
